// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: PC/IR, imem request/ready handshake, branches.
// Define FETCH_TIMEOUT_EN to abandon fetches after TIMEOUT_CYC cycles in REQ.
module sisc_fetch #(
   parameter int PC_W        = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic            clk,
   input  logic            rst_f,
   input  logic            fetch_req,
   input  logic            br_load,
   input  logic            br_rel,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rdy,
   input  logic [31:0]     imem_data,
   output logic [31:0]     ir,
   output logic [3:0]      opcode,
   output logic [3:0]      mm,
   output logic [PC_W-1:0] pc,
   output logic            ir_ready,
   output logic            busy,
   output logic            fetch_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic            to_hit;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Counter idles at zero outside REQ, so it is clear on every REQ entry.
   always_comb begin
      cnt_d  = (state_q == REQ) ? cnt_q + CNT_W'(1) : '0;
      to_hit = (state_q == REQ) && !imem_rdy &&
               (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      err_d  = err_q | to_hit;
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign fetch_err = err_q;
`else
   assign to_hit    = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!br_load && fetch_req) state_d = REQ;
         REQ:     if (imem_rdy || to_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Relative offset is the sign-extended low half of the IR.
   always_comb begin
      pc_d = pc_q;
      ir_d = ir_q;
      if (state_q == IDLE && br_load) begin
         pc_d = br_rel ? pc_q + PC_W'($signed(ir_q[15:0]))
                       : ir_q[PC_W-1:0];
      end else if (state_q == REQ && imem_rdy) begin
         ir_d = imem_data;
         pc_d = pc_q + PC_W'(1);
      end else if (to_hit) begin
         ir_d = '0;
      end
   end

   always_comb begin
      imem_req = (state_q == REQ);
      busy     = (state_q != IDLE);
      ir_ready = (state_q == DONE);
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign opcode    = ir_q[31:28];
   assign mm        = ir_q[27:24];

endmodule
